// File: rtl/sprite_draw_scheduler.sv
// Tile draw scheduler: arbitrates a full-board refresh sweep against queued single-tile
// updates, fetches each tile's sprite id from the map RAM and launches one sprite_draw slot.
module sprite_draw_scheduler #(
    parameter int BOARD_W     = 20,
    parameter int BOARD_H     = 15,
    parameter int DRAW_CYCLES = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       refresh_req,
    input  logic       upd_valid,
    output logic       upd_ready,
    input  logic [4:0] upd_col,
    input  logic [3:0] upd_row,
    output logic [4:0] map_col,
    output logic [3:0] map_row,
    input  logic [3:0] map_sprite_id,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [3:0] sprite_id_out,
    output logic       begin_draw,
    output logic       busy,
    output logic       refresh_done
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(DRAW_CYCLES + 1);

    localparam logic [4:0]        COL_LIM   = 5'(BOARD_W);
    localparam logic [4:0]        LAST_COL  = 5'(BOARD_W - 1);
    localparam logic [3:0]        ROW_LIM   = 4'(BOARD_H);
    localparam logic [3:0]        LAST_ROW  = 4'(BOARD_H - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(DRAW_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t state_r, state_s;

    // Update queue storage: entry = {row, col}
    logic [8:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  q_cnt_r;

    logic              sweep_active_r, pending_r, rr_last_r, cur_last_r;
    logic [4:0]        sweep_col_r, map_col_r;
    logic [3:0]        sweep_row_r, map_row_r;
    logic [7:0]        x_r;
    logic [6:0]        y_r;
    logic [3:0]        sprite_id_r;
    logic              begin_draw_r, refresh_done_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic              upd_ready_s, in_range_s, push_s, pop_s, q_empty_s;
    logic [4:0]        head_col_s, grant_col_s;
    logic [3:0]        head_row_s, grant_row_s;
    logic              sweep_req_s, start_sweep_s, grant_sweep_s, grant_q_s, grant_s;
    logic              grant_last_s, sweep_done_s;

    assign upd_ready_s   = (q_cnt_r != FIFO_FULL);
    assign q_empty_s     = (q_cnt_r == CNT_ZERO);
    assign in_range_s    = (upd_col < COL_LIM) && (upd_row < ROW_LIM);
    assign push_s        = upd_valid && upd_ready_s && in_range_s;
    assign pop_s         = grant_q_s;
    assign head_col_s    = fifo_mem_r[rd_ptr_r][4:0];
    assign head_row_s    = fifo_mem_r[rd_ptr_r][8:5];

    // A pending refresh counts as a sweep request in the same IDLE cycle that starts it
    assign sweep_req_s   = sweep_active_r || pending_r;
    assign start_sweep_s = (state_r == ST_IDLE) && pending_r && !sweep_active_r;
    assign grant_s       = grant_sweep_s || grant_q_s;
    assign grant_col_s   = grant_q_s ? head_col_s : sweep_col_r;
    assign grant_row_s   = grant_q_s ? head_row_s : sweep_row_r;
    assign grant_last_s  = grant_sweep_s && (sweep_col_r == LAST_COL) && (sweep_row_r == LAST_ROW);
    assign sweep_done_s  = (state_r == ST_WAIT) && (wait_cnt_r == WAIT_ZERO) && cur_last_r;

    assign upd_ready     = upd_ready_s;
    assign map_col       = map_col_r;
    assign map_row       = map_row_r;
    assign x_out         = x_r;
    assign y_out         = y_r;
    assign sprite_id_out = sprite_id_r;
    assign begin_draw    = begin_draw_r;
    assign refresh_done  = refresh_done_r;
    assign busy          = (state_r != ST_IDLE) || sweep_active_r || pending_r || !q_empty_s;

    // Arbitration and next-state decode
    always_comb begin
        grant_sweep_s = 1'b0;
        grant_q_s     = 1'b0;
        state_s       = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sweep_req_s && !q_empty_s) begin
                    if (rr_last_r) begin
                        grant_sweep_s = 1'b1;
                    end else begin
                        grant_q_s = 1'b1;
                    end
                end else if (sweep_req_s) begin
                    grant_sweep_s = 1'b1;
                end else if (!q_empty_s) begin
                    grant_q_s = 1'b1;
                end else begin
                    grant_sweep_s = 1'b0;
                    grant_q_s     = 1'b0;
                end
                if (grant_sweep_s || grant_q_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: state_s = ST_LATCH;
            ST_LATCH: state_s = ST_ISSUE;
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_ZERO) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Update queue: out-of-board requests are handshaken but dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 9'b0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            q_cnt_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {upd_row, upd_col};
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   q_cnt_r <= q_cnt_r + CNT_ONE;
                2'b01:   q_cnt_r <= q_cnt_r - CNT_ONE;
                default: q_cnt_r <= q_cnt_r;
            endcase
        end
    end

    // Sweep bookkeeping, refresh pending flag and round-robin history
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_r      <= 1'b0;
            sweep_active_r <= 1'b0;
            sweep_col_r    <= 5'd0;
            sweep_row_r    <= 4'd0;
            rr_last_r      <= 1'b0;
        end else begin
            if (refresh_req) begin
                pending_r <= 1'b1;
            end else if (start_sweep_s) begin
                pending_r <= 1'b0;
            end
            if (start_sweep_s || grant_sweep_s) begin
                sweep_active_r <= 1'b1;
            end else if (sweep_done_s) begin
                sweep_active_r <= 1'b0;
            end
            // Counters wrap to (0,0) on the last grant, ready for the next sweep
            if (grant_sweep_s) begin
                if (sweep_col_r == LAST_COL) begin
                    sweep_col_r <= 5'd0;
                    if (sweep_row_r == LAST_ROW) begin
                        sweep_row_r <= 4'd0;
                    end else begin
                        sweep_row_r <= sweep_row_r + 4'd1;
                    end
                end else begin
                    sweep_col_r <= sweep_col_r + 5'd1;
                end
            end
            if (grant_s) begin
                rr_last_r <= grant_q_s;
            end
        end
    end

    // Tile datapath and draw-slot sequencing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            map_col_r      <= 5'd0;
            map_row_r      <= 4'd0;
            cur_last_r     <= 1'b0;
            x_r            <= 8'd0;
            y_r            <= 7'd0;
            sprite_id_r    <= 4'd0;
            begin_draw_r   <= 1'b0;
            refresh_done_r <= 1'b0;
            wait_cnt_r     <= WAIT_ZERO;
        end else begin
            state_r        <= state_s;
            begin_draw_r   <= (state_s == ST_ISSUE);
            refresh_done_r <= (state_r == ST_WAIT) && (wait_cnt_r == WAIT_ONE) && cur_last_r;
            if (grant_s) begin
                map_col_r  <= grant_col_s;
                map_row_r  <= grant_row_s;
                cur_last_r <= grant_last_s;
            end
            // Map RAM data for the address presented in FETCH is valid during LATCH
            if (state_r == ST_LATCH) begin
                sprite_id_r <= map_sprite_id;
                x_r         <= {map_col_r, 3'b000};
                y_r         <= {map_row_r, 3'b000};
            end
            if (state_r == ST_ISSUE) begin
                wait_cnt_r <= WAIT_LOAD;
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != WAIT_ZERO)) begin
                wait_cnt_r <= wait_cnt_r - WAIT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler with a synchronous map RAM model and a draw log.
module tb_sprite_draw_scheduler;

    logic       clk = 1'b0;
    logic       resetn, refresh_req, upd_valid;
    logic [4:0] upd_col;
    logic [3:0] upd_row;
    logic       upd_ready;
    logic [4:0] map_col;
    logic [3:0] map_row;
    logic [3:0] map_sprite_id = 4'h0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [3:0] sprite_id_out;
    logic       begin_draw, busy, refresh_done;

    int  total = 0, bad = 0, cyc = 0, last_wait = 0;
    bit  map_mode = 1'b0;
    int  bd_time[$], bd_x[$], bd_y[$], bd_s[$], rd_time[$];
    int  tc[6] = '{0, 19, 5, 10, 2, 7};
    int  tr[6] = '{0, 14, 7, 3, 9, 12};

    sprite_draw_scheduler dut (
        .clk(clk), .resetn(resetn), .refresh_req(refresh_req),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_col(upd_col), .upd_row(upd_row),
        .map_col(map_col), .map_row(map_row), .map_sprite_id(map_sprite_id),
        .x_out(x_out), .y_out(y_out), .sprite_id_out(sprite_id_out),
        .begin_draw(begin_draw), .busy(busy), .refresh_done(refresh_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Map RAM: either constant 5 or (row*20+col)&0xF, one cycle read latency
    always @(posedge clk) begin
        if (map_mode) map_sprite_id <= 4'((int'(map_row) * 20 + int'(map_col)) & 15);
        else          map_sprite_id <= 4'h5;
    end

    always @(negedge clk) begin
        if (begin_draw === 1'b1) begin
            bd_time.push_back(cyc);
            bd_x.push_back(int'(x_out));
            bd_y.push_back(int'(y_out));
            bd_s.push_back(int'(sprite_id_out));
        end
        if (refresh_done === 1'b1) rd_time.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bd(input int max, input string tag);
        int n;
        n = 0;
        while (begin_draw !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        check(tag, begin_draw, 1);
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        check(tag, busy, 0);
    endtask

    task automatic pulse_refresh();
        refresh_req = 1'b1;
        tick(1);
        refresh_req = 1'b0;
    endtask

    initial begin
        int base, rbase, idx, nb;
        resetn = 1'b0; refresh_req = 1'b0; upd_valid = 1'b0; upd_col = 5'd0; upd_row = 4'd0;
        tick(3);
        check("rst_begin_draw", begin_draw, 0);
        check("rst_busy", busy, 0);
        check("rst_upd_ready", upd_ready, 1);
        check("rst_xy", {x_out, y_out}, 0);
        check("rst_sprite", sprite_id_out, 0);
        check("rst_map", {map_col, map_row}, 0);
        check("rst_refresh_done", refresh_done, 0);
        resetn = 1'b1;
        tick(2);

        // single update (3,2), map returns 5
        upd_valid = 1'b1; upd_col = 5'd3; upd_row = 4'd2;
        tick(1);
        upd_valid = 1'b0;
        check("t1_busy_rise", busy, 1);
        wait_bd(20, "t1_begin_draw");
        check("t1_latency", last_wait, 3);
        check("t1_x", x_out, 24);
        check("t1_y", y_out, 16);
        check("t1_sprite", sprite_id_out, 5);
        tick(1);
        check("t1_pulse_width", begin_draw, 0);
        wait_idle(200, "t1_busy_fall");
        check("t1_busy_cycles", last_wait, 65);
        check("t1_x_hold", x_out, 24);
        check("t1_y_hold", y_out, 16);
        check("t1_sprite_hold", sprite_id_out, 5);
        check("t1_no_refresh_done", rd_time.size(), 0);

        // out-of-board updates are accepted but never drawn
        upd_valid = 1'b1; upd_col = 5'd20; upd_row = 4'd0;
        check("t5_ready_col", upd_ready, 1);
        tick(1);
        check("t5_busy_col", busy, 0);
        upd_col = 5'd0; upd_row = 4'd15;
        check("t5_ready_row", upd_ready, 1);
        tick(1);
        upd_valid = 1'b0;
        check("t5_busy_row", busy, 0);
        tick(10);
        check("t5_busy_after", busy, 0);
        check("t5_no_draw", bd_time.size(), 1);

        // fill the queue while a draw is in WAIT
        upd_valid = 1'b1; upd_col = 5'd1; upd_row = 4'd1;
        tick(1);
        upd_valid = 1'b0;
        wait_bd(20, "t3_first_draw");
        tick(2);
        base = bd_time.size();
        idx = 0;
        for (int c = 0; c < 1000 && idx < 6; c++) begin
            upd_valid = 1'b1;
            upd_col = 5'(tc[idx]);
            upd_row = 4'(tr[idx]);
            if (c == 4) begin
                check("t3_accepts_before_full", idx, 4);
                check("t3_ready_full", upd_ready, 0);
            end
            if (upd_ready === 1'b1) idx++;
            tick(1);
        end
        upd_valid = 1'b0;
        check("t3_all_accepted", idx, 6);
        wait_idle(6 * 69 + 200, "t3_drain");
        tick(2);
        check("t3_draw_count", bd_time.size(), base + 6);
        for (int i = 0; i < 6; i++) begin
            check("t3_order_x", bd_x[base + i], tc[i] * 8);
            check("t3_order_y", bd_y[base + i], tr[i] * 8);
        end

        // full-board sweep with patterned map data
        map_mode = 1'b1;
        base = bd_time.size();
        rbase = rd_time.size();
        pulse_refresh();
        wait_idle(300 * 69 + 200, "t2_sweep_end");
        tick(2);
        check("t2_draw_count", bd_time.size(), base + 300);
        for (int i = 0; i < 300; i++) begin
            int c, r;
            c = i % 20;
            r = i / 20;
            check("t2_x", bd_x[base + i], c * 8);
            check("t2_y", bd_y[base + i], r * 8);
            check("t2_sprite", bd_s[base + i], (r * 20 + c) & 15);
            if (i > 0) check("t2_spacing", bd_time[base + i] - bd_time[base + i - 1], 69);
        end
        check("t2_last_x", bd_x[base + 299], 152);
        check("t2_last_y", bd_y[base + 299], 112);
        check("t2_refresh_done_count", rd_time.size(), rbase + 1);
        check("t2_refresh_done_delay", rd_time[rbase] - bd_time[base + 299], 65);

        // sweep interleaved with two queued updates
        base = bd_time.size();
        rbase = rd_time.size();
        pulse_refresh();
        wait_bd(20, "t4_first_draw");
        tick(1);
        upd_valid = 1'b1; upd_col = 5'd4; upd_row = 4'd4;
        check("t4_ready_u1", upd_ready, 1);
        tick(1);
        upd_col = 5'd6; upd_row = 4'd6;
        check("t4_ready_u2", upd_ready, 1);
        tick(1);
        upd_valid = 1'b0;
        wait_idle(302 * 69 + 200, "t4_sweep_end");
        tick(2);
        check("t4_draw_count", bd_time.size(), base + 302);
        check("t4_g0", {bd_x[base + 0], bd_y[base + 0]}, {32'd0, 32'd0});
        check("t4_g1", {bd_x[base + 1], bd_y[base + 1]}, {32'd32, 32'd32});
        check("t4_g2", {bd_x[base + 2], bd_y[base + 2]}, {32'd8, 32'd0});
        check("t4_g3", {bd_x[base + 3], bd_y[base + 3]}, {32'd48, 32'd48});
        check("t4_g4", {bd_x[base + 4], bd_y[base + 4]}, {32'd16, 32'd0});
        check("t4_g5", {bd_x[base + 5], bd_y[base + 5]}, {32'd24, 32'd0});
        check("t4_last", {bd_x[base + 301], bd_y[base + 301]}, {32'd152, 32'd112});
        check("t4_refresh_done_count", rd_time.size(), rbase + 1);

        // reset in the middle of a sweep
        pulse_refresh();
        for (int k = 0; k < 3; k++) begin
            wait_bd(100, "t6_pre_draw");
            tick(1);
        end
        tick(20);
        resetn = 1'b0;
        tick(1);
        check("t6_rst_begin_draw", begin_draw, 0);
        check("t6_rst_xy", {x_out, y_out}, 0);
        check("t6_rst_sprite", sprite_id_out, 0);
        check("t6_rst_map", {map_col, map_row}, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", upd_ready, 1);
        resetn = 1'b1;
        nb = bd_time.size();
        rbase = rd_time.size();
        tick(200);
        check("t6_no_draw", bd_time.size(), nb);
        check("t6_no_refresh_done", rd_time.size(), rbase);
        check("t6_busy", busy, 0);
        check("t6_xy", {x_out, y_out}, 0);
        check("t6_ready", upd_ready, 1);
        pulse_refresh();
        wait_bd(20, "t6_restart_draw");
        check("t6_restart_x", x_out, 0);
        check("t6_restart_y", y_out, 0);
        check("t6_restart_sprite", sprite_id_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
Sequences the 8x8 sprite drawing engine over a 20x15 tile board (160x120 screen). It arbitrates between two requesters: a full-board refresh sweep and a queue of single-tile redraw requests from game logic. For each granted tile it reads the sprite id from the board map RAM, then drives x/y/sprite_id and a one-cycle begin_draw pulse into sprite_draw. It holds those outputs for the full draw slot.

Parameters:
BOARD_W, 20, tiles per row (column index 0..BOARD_W-1)
BOARD_H, 15, tiles per column (row index 0..BOARD_H-1)
DRAW_CYCLES, 64, pixels written by sprite_draw per tile
FIFO_DEPTH, 4, tile-update queue entries (power of 2)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
refresh_req  in  1  pulse: redraw the whole board
upd_valid  in  1  tile-update request valid
upd_ready  out  1  queue can accept; equals !full
upd_col  in  5  tile column of update
upd_row  in  4  tile row of update
map_col  out  5  board map RAM read column
map_row  out  4  board map RAM read row
map_sprite_id  in  4  map RAM read data; synchronous, valid 1 cycle after address
x_out  out  8  pixel x anchor to sprite_draw (x_in)
y_out  out  7  pixel y anchor to sprite_draw (y_in)
sprite_id_out  out  4  sprite id to sprite_draw (sprite_id_in)
begin_draw  out  1  one-cycle start pulse to sprite_draw
busy  out  1  state!=IDLE or sweep pending/active or queue non-empty
refresh_done  out  1  one-cycle pulse when a sweep finishes its last tile

Behaviour:
- Reset (async, resetn=0): state=IDLE. x_out, y_out, sprite_id_out, map_col, map_row, begin_draw, refresh_done and busy all 0. upd_ready=1. Queue emptied; sweep inactive, sweep counters (0,0); refresh pending cleared; rr_last=0. Reset mid-draw abandons the tile and issues no further pulses.
- Queue: push when upd_valid && upd_ready. Requests with upd_col>=BOARD_W or upd_row>=BOARD_H are accepted but discarded (not enqueued). While full, upd_ready=0. A pop and a push in the same cycle are both honoured.
- Refresh: refresh_req sets the pending flag. In IDLE, pending with no active sweep starts a sweep at (0,0) and clears pending. A refresh_req during an active sweep stays pending; a new sweep starts right after the current one completes.
- Arbitration happens in IDLE only:
  - Sweep active and queue empty: grant sweep.
  - Queue non-empty and no active sweep: grant queue.
  - Both: round-robin opposite rr_last (0=sweep last, 1=queue last); rr_last updates on every grant.
  - Neither: stay in IDLE.
- FSM:
  - IDLE -> FETCH on grant. The granted tile (col,row) is latched and the queue pops if granted.
  - FETCH: map_col/map_row = tile; -> LATCH.
  - LATCH: capture map_sprite_id into sprite_id_out; x_out = col<<3; y_out = row<<3 (zero-extended, max 152/112, no overflow); -> ISSUE.
  - ISSUE: begin_draw=1 for exactly this cycle; -> WAIT with counter = DRAW_CYCLES.
  - WAIT: counter decrements each cycle; at 0 -> IDLE. WAIT lasts DRAW_CYCLES+1 cycles, covering sprite_draw's load-wait cycle plus 64 draw cycles.
- x_out, y_out and sprite_id_out hold stable from LATCH until the next LATCH.
- Per-tile service is 69 cycles (IDLE 1 + FETCH 1 + LATCH 1 + ISSUE 1 + WAIT 65). Under back-to-back grants, begin_draw rising edges are exactly 69 cycles apart.
- Sweep order is row-major: col increments; at col=BOARD_W-1, col wraps to 0 and row increments. When the WAIT of tile (BOARD_W-1, BOARD_H-1) exits, refresh_done pulses 1 cycle and the sweep becomes inactive (or restarts if pending).

Test Plan:
- Reset, then push upd (col=3,row=2) with map returning 0x5 -> begin_draw one cycle; x_out=24, y_out=16, sprite_id_out=5, held 66+ cycles; busy drops after 69 cycles; no refresh_done.
- refresh_req with map data = (row*BOARD_W+col)&0xF -> 300 begin_draw pulses, 69 cycles apart, in row-major order; last pulse x=152, y=112; refresh_done exactly once, 65 cycles after the last pulse.
- Hold upd_valid with 6 distinct tiles while a draw is in WAIT -> upd_ready falls after 4 accepts; the remaining requests are accepted as entries pop; all 6 are drawn in FIFO order.
- Sweep active plus 2 queued updates -> grants alternate: sweep, queue, sweep, queue, then sweep only; refresh_done still asserts after 300 sweep tiles.
- upd (col=20,row=0) and upd (col=0,row=15) -> accepted with upd_ready=1, no begin_draw, busy stays 0.
- Assert resetn=0 during WAIT mid-sweep, release, idle 200 cycles -> no begin_draw, outputs 0, upd_ready=1; a new refresh_req starts again at (0,0).
